vga_fb_arbiter: RTL and testbench

- Shares one single-port synchronous framebuffer RAM between two requesters: the VGA line prefetcher and the game-logic pixel writer.
- On each line request from the VGA timing block, the arbiter copies LINE_WORDS words of that line from the framebuffer into the scan-out line buffer.
- Game-logic writes are granted on guaranteed periodic slots, so the display fetch always finishes within a bounded time.

---
 rtl/vga_fb_arbiter.sv | 116 +++++++++++
 tb/tb_vga_fb_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: copies one display line into the scan-out line buffer
// while granting the game-logic writer a guaranteed slot every WR_PERIOD cycles.
module vga_fb_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int LINE_WORDS = 80,
    parameter int LB_ADDR_W  = 7,
    parameter int WR_PERIOD  = 4,
    parameter int FB_BASE    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 line_req,
    input  logic [9:0]           line_num,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_we,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 lb_we,
    output logic [LB_ADDR_W-1:0] lb_addr,
    output logic [DATA_W-1:0]    lb_data,
    output logic                 fetch_busy,
    output logic                 fetch_done,
    output logic                 overrun
);
    localparam int SLOT_W = $clog2(WR_PERIOD);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [LB_ADDR_W-1:0] idx;
    logic [SLOT_W-1:0]   slot_ctr;
    logic [ADDR_W-1:0]   line_base;
    logic                slot_hit, rd_issue, last_word;

    assign slot_hit  = (state == FETCH) && (slot_ctr == SLOT_W'(WR_PERIOD - 1));
    assign last_word = (idx == LB_ADDR_W'(LINE_WORDS - 1));
    assign lb_data   = mem_rdata;

    always_comb begin
        state_nxt = state;
        rd_issue  = 1'b0;
        wr_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE, DRAIN: begin
                wr_ready  = 1'b1;
                mem_we    = wr_valid;
                mem_addr  = wr_addr;
                mem_wdata = wr_data;
                if (state == DRAIN)
                    state_nxt = IDLE;
                else if (line_req)
                    state_nxt = FETCH;
            end
            FETCH: begin
                wr_ready = slot_hit;
                if (slot_hit && wr_valid) begin
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                end else begin
                    // unused writer slots fall through to the fetch
                    rd_issue = 1'b1;
                    mem_addr = line_base + ADDR_W'(idx);
                    if (last_word)
                        state_nxt = DRAIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!reset) begin
            wr_ready  = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    assign fetch_busy = reset && (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= '0;
            slot_ctr   <= '0;
            line_base  <= '0;
            lb_we      <= 1'b0;
            lb_addr    <= '0;
            fetch_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            lb_we      <= rd_issue;
            fetch_done <= rd_issue && last_word;
            overrun    <= line_req && (state != IDLE);
            if (rd_issue)
                lb_addr <= idx;
            if (state == IDLE && line_req) begin
                line_base <= ADDR_W'(FB_BASE + int'(line_num) * LINE_WORDS);
                idx       <= '0;
                slot_ctr  <= '0;
            end else if (state == FETCH) begin
                slot_ctr <= slot_hit ? '0 : slot_ctr + 1'b1;
                if (rd_issue)
                    idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: line fetch timing, writer slots,
// overrun, reset abort and framebuffer address wrap.
module tb_vga_fb_arbiter;
    logic        clk, reset, line_req, wr_valid;
    logic [9:0]  line_num;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data, mem_rdata;
    logic        wr_ready, mem_we, lb_we, fetch_busy, fetch_done, overrun;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata, lb_data;
    logic [2:0]  lb_addr;

    logic [5:0]  wr_addr6, mem_addr6;
    logic        wr_ready6, mem_we6, lb_we6, fetch_busy6, fetch_done6, overrun6;
    logic [7:0]  mem_wdata6, lb_data6;
    logic [2:0]  lb_addr6;
    assign wr_addr6 = wr_addr[5:0];

    int errs = 0;
    int nchk = 0;

    vga_fb_arbiter #(.ADDR_W(17), .DATA_W(8), .LINE_WORDS(8), .LB_ADDR_W(3),
                     .WR_PERIOD(4), .FB_BASE(0)) u_dut (
        .clk(clk), .reset(reset), .line_req(line_req), .line_num(line_num),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
        .fetch_busy(fetch_busy), .fetch_done(fetch_done), .overrun(overrun));

    vga_fb_arbiter #(.ADDR_W(6), .DATA_W(8), .LINE_WORDS(8), .LB_ADDR_W(3),
                     .WR_PERIOD(4), .FB_BASE(0)) u_dut6 (
        .clk(clk), .reset(reset), .line_req(line_req), .line_num(line_num),
        .wr_valid(wr_valid), .wr_ready(wr_ready6), .wr_addr(wr_addr6), .wr_data(wr_data),
        .mem_addr(mem_addr6), .mem_we(mem_we6), .mem_wdata(mem_wdata6), .mem_rdata(mem_rdata),
        .lb_we(lb_we6), .lb_addr(lb_addr6), .lb_data(lb_data6),
        .fetch_busy(fetch_busy6), .fetch_done(fetch_done6), .overrun(overrun6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    int ea[10] = '{16, 17, 18, 256, 19, 20, 21, 256, 22, 23};
    int ew[10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};

    initial begin
        int k, dones, lbs;
        reset = 1'b0; line_req = 1'b1; line_num = 10'd0; wr_valid = 1'b1;
        wr_addr = 17'h155; wr_data = 8'hFF; mem_rdata = 8'hA5;

        // 1: reset held with requests driven
        repeat (3) @(posedge clk);
        #3;
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_busy", 32'(fetch_busy), 32'd0);
        check("rst_lb_we", 32'(lb_we), 32'd0);
        check("rst_lb_addr", 32'(lb_addr), 32'd0);
        check("rst_done", 32'(fetch_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        line_req = 1'b0; wr_valid = 1'b0;
        next_cyc(); reset = 1'b1;
        next_cyc(); next_cyc(); #3;
        check("rel_wr_ready", 32'(wr_ready), 32'd1);
        check("rel_lb_we", 32'(lb_we), 32'd0);
        check("rel_busy", 32'(fetch_busy), 32'd0);

        // 2: plain fetch of line 2
        next_cyc(); line_req = 1'b1; line_num = 10'd2; #3;
        check("t2_busy0", 32'(fetch_busy), 32'd0);
        for (int c = 1; c <= 10; c++) begin
            next_cyc(); line_req = 1'b0; #3;
            check($sformatf("t2_busy_c%0d", c), 32'(fetch_busy), 32'(c <= 9));
            check($sformatf("t2_lbwe_c%0d", c), 32'(lb_we), 32'(c >= 2 && c <= 9));
            if (c >= 2 && c <= 9)
                check($sformatf("t2_lbaddr_c%0d", c), 32'(lb_addr), 32'(c - 2));
            check($sformatf("t2_done_c%0d", c), 32'(fetch_done), 32'(c == 9));
            if (c <= 8) begin
                check($sformatf("t2_addr_c%0d", c), 32'(mem_addr), 32'(16 + c - 1));
                check($sformatf("t2_we_c%0d", c), 32'(mem_we), 32'd0);
            end
        end
        check("t2_lb_data", 32'(lb_data), 32'hA5);

        // 3: fetch with writer always requesting
        next_cyc(); line_req = 1'b1; line_num = 10'd2; wr_valid = 1'b1;
        wr_addr = 17'h100; wr_data = 8'h3C; #3;
        check("t3_idle_we", 32'(mem_we), 32'd1);
        check("t3_idle_addr", 32'(mem_addr), 32'h100);
        k = 0;
        for (int c = 1; c <= 12; c++) begin
            next_cyc(); line_req = 1'b0; #3;
            if (c <= 10) begin
                check($sformatf("t3_addr_c%0d", c), 32'(mem_addr), 32'(ea[c-1]));
                check($sformatf("t3_we_c%0d", c), 32'(mem_we), 32'(ew[c-1]));
                check($sformatf("t3_rdy_c%0d", c), 32'(wr_ready), 32'(ew[c-1]));
                if (ew[c-1] == 1)
                    check($sformatf("t3_wdata_c%0d", c), 32'(mem_wdata), 32'h3C);
            end
            if (c >= 2 && c <= 11 && ew[c-2] == 0) begin
                check($sformatf("t3_lbwe_c%0d", c), 32'(lb_we), 32'd1);
                check($sformatf("t3_lbaddr_c%0d", c), 32'(lb_addr), 32'(k));
                k++;
            end else begin
                check($sformatf("t3_lbwe_c%0d", c), 32'(lb_we), 32'd0);
            end
            check($sformatf("t3_done_c%0d", c), 32'(fetch_done), 32'(c == 11));
            if (c == 11) begin
                check("t3_drain_rdy", 32'(wr_ready), 32'd1);
                check("t3_drain_we", 32'(mem_we), 32'd1);
            end
        end
        check("t3_lb_count", 32'(k), 32'd8);
        wr_valid = 1'b0;

        // 4: line_req during FETCH and during DRAIN
        next_cyc(); line_req = 1'b1; line_num = 10'd2; #3;
        dones = 0;
        for (int c = 1; c <= 11; c++) begin
            next_cyc();
            line_req = (c == 5 || c == 9);
            line_num = (c == 5 || c == 9) ? 10'd5 : 10'd2;
            #3;
            check($sformatf("t4_ovr_c%0d", c), 32'(overrun), 32'(c == 6 || c == 10));
            check($sformatf("t4_busy_c%0d", c), 32'(fetch_busy), 32'(c <= 9));
            if (c <= 8)
                check($sformatf("t4_addr_c%0d", c), 32'(mem_addr), 32'(16 + c - 1));
            if (fetch_done) dones++;
        end
        line_req = 1'b0;
        check("t4_done_count", 32'(dones), 32'd1);

        // 5: reset mid-fetch
        next_cyc(); line_req = 1'b1; line_num = 10'd2; #3;
        for (int c = 1; c <= 4; c++) begin
            next_cyc(); line_req = 1'b0; #3;
        end
        check("t5_lbwe_pre", 32'(lb_we), 32'd1);
        wr_valid = 1'b1;
        reset = 1'b0; #1;
        check("t5_lbwe_rst", 32'(lb_we), 32'd0);
        check("t5_rdy_rst", 32'(wr_ready), 32'd0);
        check("t5_busy_rst", 32'(fetch_busy), 32'd0);
        check("t5_we_rst", 32'(mem_we), 32'd0);
        wr_valid = 1'b0;
        next_cyc(); next_cyc(); reset = 1'b1;
        lbs = 0; dones = 0;
        for (int c = 0; c < 12; c++) begin
            next_cyc(); #3;
            if (lb_we) lbs++;
            if (fetch_done) dones++;
        end
        check("t5_lbwe_after", 32'(lbs), 32'd0);
        check("t5_done_after", 32'(dones), 32'd0);
        check("t5_rdy_after", 32'(wr_ready), 32'd1);
        check("t5_busy_after", 32'(fetch_busy), 32'd0);

        // 6: line base wraps with a 6-bit address
        next_cyc(); line_req = 1'b1; line_num = 10'd8; #3;
        for (int c = 1; c <= 10; c++) begin
            next_cyc(); line_req = 1'b0; #3;
            if (c <= 8) begin
                check($sformatf("t6_addr6_c%0d", c), 32'(mem_addr6), 32'(c - 1));
                check($sformatf("t6_addr17_c%0d", c), 32'(mem_addr), 32'(64 + c - 1));
            end
        end
        check("t6_done6", 32'(fetch_done6), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
